// File: rtl/rect_rasterizer_pkg.sv
// Shared types and constants for the rectangle rasterizer.
// Framebuffer geometry, command bundle and scan FSM states.
package rect_rasterizer_pkg;

    localparam int COOR_WIDTH = 12;
    localparam int FB_W       = 1280;
    localparam int FB_H       = 300;
    localparam int EXT_W      = COOR_WIDTH + 1;

    typedef struct packed {
        logic [COOR_WIDTH-1:0] x;
        logic [COOR_WIDTH-1:0] y;
        logic [COOR_WIDTH-1:0] w;
        logic [COOR_WIDTH-1:0] h;
        logic [1:0]            palette;
        logic                  outline;
    } rect_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAW
    } rast_state_e;

    // Exclusive end coordinate, clipped to the framebuffer edge.
    function automatic logic [EXT_W-1:0] clip_end(
        input logic [COOR_WIDTH-1:0] org,
        input logic [COOR_WIDTH-1:0] len,
        input int                    lim
    );
        logic [EXT_W-1:0] sum;
        logic [EXT_W-1:0] cap;
        sum = {1'b0, org} + {1'b0, len};
        cap = EXT_W'(lim);
        return (sum > cap) ? cap : sum;
    endfunction

endpackage

// File: rtl/rect_cmd_fifo.sv
// Synchronous FIFO of rectangle commands.
// Pointers carry one wrap bit to tell full from empty.
module rect_cmd_fifo
    import rect_rasterizer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  rect_cmd_t din,
    input  logic      pop,
    output rect_cmd_t dout,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    rect_cmd_t      mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rect_rasterizer.sv
// Row-major rectangle scan feeding the framebuffer write port.
// Define OUTLINE_EN to honour cmd_outline (border-only drawing).
module rect_rasterizer
    import rect_rasterizer_pkg::*;
#(
    parameter int COOR_WIDTH = rect_rasterizer_pkg::COOR_WIDTH,
    parameter int FB_W       = rect_rasterizer_pkg::FB_W,
    parameter int FB_H       = rect_rasterizer_pkg::FB_H,
    parameter int CMD_DEPTH  = 4
) (
    input  logic                  clk_33m,
    input  logic                  rst_n,
    input  logic                  rst_screen_33m,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [COOR_WIDTH-1:0] cmd_x,
    input  logic [COOR_WIDTH-1:0] cmd_y,
    input  logic [COOR_WIDTH-1:0] cmd_w,
    input  logic [COOR_WIDTH-1:0] cmd_h,
    input  logic [1:0]            cmd_palette,
    input  logic                  cmd_outline,
    output logic [COOR_WIDTH-1:0] write_x,
    output logic [COOR_WIDTH-1:0] write_y,
    output logic [1:0]            write_palette,
    output logic                  busy,
    output logic                  frame_start
);

    localparam int EW = COOR_WIDTH + 1;

    rect_cmd_t             cmd_in;
    rect_cmd_t             head;
    rect_cmd_t             cur;
    rast_state_e           state_q;
    rast_state_e           state_d;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic                  stall;
    logic                  reject;
    logic                  row_end;
    logic                  last_row;
    logic [COOR_WIDTH-1:0] cx;
    logic [COOR_WIDTH-1:0] cy;
    logic [EW-1:0]         x_end;
    logic [EW-1:0]         y_end;
    logic [1:0]            pix_pal;
    logic                  rs_q;

    assign cmd_in = '{
        x:       cmd_x,
        y:       cmd_y,
        w:       cmd_w,
        h:       cmd_h,
        palette: cmd_palette,
        outline: cmd_outline
    };

    assign stall     = rst_screen_33m;
    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == IDLE) && !fifo_empty && !stall;
    assign busy      = !fifo_empty || (state_q != IDLE);

    rect_cmd_fifo #(
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk   (clk_33m),
        .rst_n (rst_n),
        .push  (push),
        .din   (cmd_in),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign reject = (cur.w == '0) || (cur.h == '0) ||
                    ({1'b0, cur.x} >= EW'(FB_W)) ||
                    ({1'b0, cur.y} >= EW'(FB_H)) ||
                    (cur.palette == 2'b00);

    assign row_end  = (({1'b0, cx} + 1'b1) == x_end);
    assign last_row = (({1'b0, cy} + 1'b1) == y_end);

`ifdef OUTLINE_EN
    logic border;
    assign border  = (cx == cur.x) || row_end ||
                     (cy == cur.y) || last_row;
    assign pix_pal = (cur.outline && !border) ? 2'b00 : cur.palette;
`else
    logic unused_outline;
    assign unused_outline = cur.outline;
    assign pix_pal        = cur.palette;
`endif

    always_ff @(posedge clk_33m or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The swap window freezes every state, including IDLE.
    always_comb begin
        state_d = state_q;
        if (!stall) begin
            unique case (state_q)
                IDLE:    if (!fifo_empty) state_d = LOAD;
                LOAD:    state_d = reject ? IDLE : DRAW;
                DRAW:    if (row_end && last_row) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_33m or negedge rst_n) begin
        if (!rst_n) begin
            cur   <= '0;
            cx    <= '0;
            cy    <= '0;
            x_end <= '0;
            y_end <= '0;
        end else if (!stall) begin
            unique case (state_q)
                IDLE: begin
                    if (pop) cur <= head;
                end
                LOAD: begin
                    x_end <= clip_end(cur.x, cur.w, FB_W);
                    y_end <= clip_end(cur.y, cur.h, FB_H);
                    cx    <= cur.x;
                    cy    <= cur.y;
                end
                DRAW: begin
                    if (row_end) begin
                        cx <= cur.x;
                        if (!last_row) cy <= cy + 1'b1;
                    end else begin
                        cx <= cx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_33m or negedge rst_n) begin
        if (!rst_n) begin
            write_x       <= '0;
            write_y       <= '0;
            write_palette <= '0;
            rs_q          <= 1'b0;
            frame_start   <= 1'b0;
        end else begin
            rs_q        <= rst_screen_33m;
            frame_start <= rs_q && !rst_screen_33m;
            if ((state_q == DRAW) && !stall) begin
                write_x       <= cx;
                write_y       <= cy;
                write_palette <= pix_pal;
            end else begin
                write_palette <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rect_rasterizer.sv
// Directed bench for rect_rasterizer: vector table plus
// hand-written stall, back-to-back and reset sequences.
module tb_rect_rasterizer;

    localparam int CW = 12;

    logic          clk_33m = 1'b0;
    logic          rst_n = 1'b0;
    logic          rst_screen_33m = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [CW-1:0] cmd_x = '0;
    logic [CW-1:0] cmd_y = '0;
    logic [CW-1:0] cmd_w = '0;
    logic [CW-1:0] cmd_h = '0;
    logic [1:0]    cmd_palette = '0;
    logic          cmd_outline = 1'b0;
    logic [CW-1:0] write_x;
    logic [CW-1:0] write_y;
    logic [1:0]    write_palette;
    logic          busy;
    logic          frame_start;

    rect_rasterizer #(
        .COOR_WIDTH (CW),
        .FB_W       (1280),
        .FB_H       (300),
        .CMD_DEPTH  (4)
    ) dut (
        .clk_33m        (clk_33m),
        .rst_n          (rst_n),
        .rst_screen_33m (rst_screen_33m),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_x          (cmd_x),
        .cmd_y          (cmd_y),
        .cmd_w          (cmd_w),
        .cmd_h          (cmd_h),
        .cmd_palette    (cmd_palette),
        .cmd_outline    (cmd_outline),
        .write_x        (write_x),
        .write_y        (write_y),
        .write_palette  (write_palette),
        .busy           (busy),
        .frame_start    (frame_start)
    );

    always #15 clk_33m = ~clk_33m;

    int cyc = 0;
    always @(posedge clk_33m) cyc <= cyc + 1;

    typedef struct {
        int x;
        int y;
        int p;
        int c;
    } pix_t;

    pix_t pix_q[$];
    int   fs_q[$];

    always @(negedge clk_33m) begin
        if (write_palette != 2'b00)
            pix_q.push_back('{int'(write_x), int'(write_y),
                             int'(write_palette), cyc});
        if (frame_start) fs_q.push_back(cyc);
    end

    typedef struct {
        int x; int y; int w; int h; int pal; int outl;
        int n; int fx; int fy; int lx; int ly;
    } vec_t;

    vec_t vt[$];
    int   n_tests = 0;
    int   n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_33m);
        #2;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick();
    endtask

    task automatic clear_logs();
        pix_q.delete();
        fs_q.delete();
    endtask

    // Offers one command and returns the cycle index of its handshake.
    task automatic send(input int x, input int y, input int w, input int h,
                        input int pal, input int outl, output int hs);
        int budget;
        cmd_x       = CW'(x);
        cmd_y       = CW'(y);
        cmd_w       = CW'(w);
        cmd_h       = CW'(h);
        cmd_palette = 2'(pal);
        cmd_outline = outl[0];
        cmd_valid   = 1'b1;
        budget      = 0;
        while (!cmd_ready && budget < 60) begin
            tick();
            budget++;
        end
        if (!cmd_ready) check("send_ready_timeout", 0, 1);
        tick();
        hs        = cyc;
        cmd_valid = 1'b0;
    endtask

    initial begin
        int hs;
        int hs_b;
        int h0;
        int budget;
        int cnt;
        int exp_x[8];
        int exp_p[8];

        vt.push_back('{10, 5, 3, 2, 2, 0, 6, 10, 5, 12, 6});
        vt.push_back('{1278, 299, 5, 5, 1, 0, 2, 1278, 299, 1279, 299});
        vt.push_back('{5, 5, 0, 3, 1, 0, 0, 0, 0, 0, 0});
        vt.push_back('{5, 5, 3, 0, 1, 0, 0, 0, 0, 0, 0});
        vt.push_back('{1280, 0, 4, 4, 3, 0, 0, 0, 0, 0, 0});
        vt.push_back('{0, 300, 4, 4, 3, 0, 0, 0, 0, 0, 0});
        vt.push_back('{0, 0, 4, 4, 0, 0, 0, 0, 0, 0, 0});
        vt.push_back('{0, 0, 1, 1, 3, 0, 1, 0, 0, 0, 0});
        vt.push_back('{100, 10, 2, 3, 1, 0, 6, 100, 10, 101, 12});
        vt.push_back('{5, 298, 2, 10, 3, 0, 4, 5, 298, 6, 299});
`ifndef OUTLINE_EN
        vt.push_back('{0, 0, 3, 3, 2, 1, 9, 0, 0, 2, 2});
`endif

        #5;
        check("rst_write_x", int'(write_x), 0);
        check("rst_write_y", int'(write_y), 0);
        check("rst_palette", int'(write_palette), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_frame_start", int'(frame_start), 0);
        check("rst_cmd_ready", int'(cmd_ready), 1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        foreach (vt[i]) begin
            clear_logs();
            send(vt[i].x, vt[i].y, vt[i].w, vt[i].h,
                 vt[i].pal, vt[i].outl, hs);
            wait_until(hs + 30);
            check($sformatf("v%0d_count", i), pix_q.size(), vt[i].n);
            if (vt[i].n > 0 && pix_q.size() > 0) begin
                check($sformatf("v%0d_first_x", i), pix_q[0].x, vt[i].fx);
                check($sformatf("v%0d_first_y", i), pix_q[0].y, vt[i].fy);
                check($sformatf("v%0d_last_x", i),
                      pix_q[pix_q.size()-1].x, vt[i].lx);
                check($sformatf("v%0d_last_y", i),
                      pix_q[pix_q.size()-1].y, vt[i].ly);
                check($sformatf("v%0d_latency", i), pix_q[0].c - hs, 3);
                check($sformatf("v%0d_contig", i),
                      pix_q[pix_q.size()-1].c - pix_q[0].c + 1, vt[i].n);
                check($sformatf("v%0d_palette", i), pix_q[0].p, vt[i].pal);
            end
            check($sformatf("v%0d_busy_end", i), int'(busy), 0);
        end

        // Back-to-back commands: two idle cycles between rectangles.
        clear_logs();
        send(0, 0, 2, 1, 1, 0, hs);
        send(20, 20, 2, 1, 2, 0, hs_b);
        wait_until(hs + 15);
        check("b2b_count", pix_q.size(), 4);
        if (pix_q.size() == 4) begin
            check("b2b_a_last_cyc", pix_q[1].c - hs, 4);
            check("b2b_gap", pix_q[2].c - pix_q[1].c, 3);
            check("b2b_b_first_x", pix_q[2].x, 20);
            check("b2b_b_pal", pix_q[2].p, 2);
        end

        // Swap window mid-rectangle with the FIFO pushed to full.
        clear_logs();
        send(0, 10, 3, 1, 1, 0, h0);
        budget = 0;
        while (pix_q.size() == 0 && budget < 20) begin
            tick();
            budget++;
        end
        check("stall_first_cyc", cyc - h0, 3);
        rst_screen_33m = 1'b1;
        send(10, 50, 1, 1, 1, 0, hs);
        send(20, 50, 1, 1, 2, 0, hs);
        send(30, 50, 1, 1, 3, 0, hs);
        send(40, 50, 1, 1, 1, 0, hs);
        check("full_ready_low", int'(cmd_ready), 0);
        check("full_busy", int'(busy), 1);
        cmd_x       = CW'(50);
        cmd_y       = CW'(50);
        cmd_w       = CW'(1);
        cmd_h       = CW'(1);
        cmd_palette = 2'd2;
        cmd_outline = 1'b0;
        cmd_valid   = 1'b1;
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            cnt += int'(cmd_ready);
        end
        check("full_ready_held", cnt, 0);
        wait_until(h0 + 11);
        rst_screen_33m = 1'b0;
        budget = 0;
        while (!cmd_ready && budget < 60) begin
            tick();
            budget++;
        end
        check("fifth_accepted", int'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
        budget = 0;
        while (busy && budget < 100) begin
            tick();
            budget++;
        end
        tick();
        check("stall_drain_busy", int'(busy), 0);
        cnt = 0;
        foreach (pix_q[i])
            if (pix_q[i].c >= h0 + 4 && pix_q[i].c <= h0 + 11) cnt++;
        check("stall_palette_zero", cnt, 0);
        check("stall_total", pix_q.size(), 8);
        exp_x = '{0, 1, 2, 10, 20, 30, 40, 50};
        exp_p = '{1, 1, 1, 1, 2, 3, 1, 2};
        if (pix_q.size() == 8) begin
            check("resume_cyc", pix_q[1].c - h0, 12);
            check("resume_y", pix_q[1].y, 10);
            for (int i = 0; i < 8; i++) begin
                check($sformatf("order_x%0d", i), pix_q[i].x, exp_x[i]);
                check($sformatf("order_p%0d", i), pix_q[i].p, exp_p[i]);
            end
        end
        check("frame_start_count", fs_q.size(), 1);
        if (fs_q.size() == 1)
            check("frame_start_cyc", fs_q[0] - h0, 12);

`ifdef OUTLINE_EN
        // Outline: interior (1,1) and (2,1) carry palette 0.
        clear_logs();
        send(0, 0, 4, 3, 3, 1, hs);
        for (int k = 0; k < 12; k++) begin
            wait_until(hs + 3 + k);
            check($sformatf("ol_x%0d", k), int'(write_x), k % 4);
            check($sformatf("ol_y%0d", k), int'(write_y), k / 4);
            check($sformatf("ol_p%0d", k), int'(write_palette),
                  ((k / 4 == 1) && (k % 4 == 1 || k % 4 == 2)) ? 0 : 3);
        end
        wait_until(hs + 15);
        check("ol_after_pal", int'(write_palette), 0);
        check("ol_count", pix_q.size(), 10);
        check("ol_busy", int'(busy), 0);
`endif

        // Asynchronous reset in the middle of a rectangle.
        clear_logs();
        send(5, 7, 10, 1, 2, 0, hs);
        send(40, 40, 2, 2, 3, 0, hs_b);
        wait_until(hs + 5);
        check("pre_rst_x", int'(write_x), 7);
        rst_n = 1'b0;
        #1;
        check("async_rst_x", int'(write_x), 0);
        check("async_rst_y", int'(write_y), 0);
        check("async_rst_pal", int'(write_palette), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_ready", int'(cmd_ready), 1);
        tick();
        rst_n = 1'b1;
        clear_logs();
        for (int k = 0; k < 20; k++) tick();
        check("post_rst_pixels", pix_q.size(), 0);
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_ready", int'(cmd_ready), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
